// File: rtl/altair_pkg.sv
// Shared types and constants for the Altair host serial loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package altair_pkg;

    // Loader frame-parsing states.
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_A_HI,
        LD_A_LO,
        LD_L_HI,
        LD_L_LO,
        LD_DATA,
        LD_CHK
    } ld_state_t;

    // Receiver bit-timing states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h55;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/altair_serial_loader_if.sv
// Memory write port plus loader status, shared between loader and write mux.
// Latency: n/a (wires only).
// Backpressure: none; the memory side must accept every mem_we strobe.
interface altair_serial_loader_if;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    modport master (output mem_we, mem_addr, mem_data, busy, done, err, err_code);
    modport slave  (input  mem_we, mem_addr, mem_data, busy, done, err, err_code);
endinterface

// File: rtl/altair_serial_loader_uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling, LSB-first shift.
// Latency: valid/frame_err pulse one clock after the stop-bit midpoint sample.
// Backpressure: none; each byte is presented for exactly one cycle.
module uart_rx
    import altair_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CW      = $clog2(BIT_CYC + 1);

    logic            rx_s1, rx_s2, rx_d;
    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shreg, sh_n;
    logic            valid_n, ferr_n;

    // Synchronise the asynchronous line; rx_d is one more stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= sh_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // Bit timing: confirm start at half a bit, then sample every full bit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_idx;
        sh_n    = shreg;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_d && !rx_s2) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(BIT_CYC - 1)) begin
                    cnt_n = '0;
                    sh_n  = {rx_s2, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(BIT_CYC - 1)) begin
                    state_n = RX_IDLE;
                    valid_n = rx_s2;
                    ferr_n  = !rx_s2;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign data = shreg;

endmodule

// File: rtl/altair_serial_loader.sv
// Host-to-memory loader: parses SYNC/ADDR/LEN/DATA/CHK frames into byte writes.
// Latency: mem_we, done and err register one clock after the receiver byte strobe.
// Backpressure: none; writes commit immediately and the memory port must accept them.
module altair_serial_loader
    import altair_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    rx,
    altair_serial_loader_if.master  ld
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]    rx_data;
    logic          rx_vld, rx_ferr;

    ld_state_t     state, state_n;
    logic [15:0]   cur_addr, cur_addr_n;
    logic [15:0]   remain, remain_n;
    logic [7:0]    csum, csum_n, csum_add;
    logic [TW-1:0] tmo, tmo_n;
    logic          we_q, we_n, done_q, done_n, err_q, err_n;
    logic [15:0]   addr_q, addr_n;
    logic [7:0]    data_q, data_n;
    logic [1:0]    code_q, code_n;
    logic          abort;
    logic [1:0]    abort_code;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_vld),
        .frame_err (rx_ferr)
    );

    assign csum_add = csum + rx_data;

    // Frame state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LD_IDLE;
            cur_addr <= '0;
            remain   <= '0;
            csum     <= '0;
            tmo      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state    <= state_n;
            cur_addr <= cur_addr_n;
            remain   <= remain_n;
            csum     <= csum_n;
            tmo      <= tmo_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            done_q   <= done_n;
            err_q    <= err_n;
            code_q   <= code_n;
        end
    end

    // Next-state: abort sources take priority over the byte in the same cycle.
    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        remain_n   = remain;
        csum_n     = csum;
        tmo_n      = (tmo == TW'(TIMEOUT_CYC)) ? tmo : tmo + TW'(1);
        we_n       = 1'b0;
        addr_n     = addr_q;
        data_n     = data_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        code_n     = code_q;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        if (state == LD_IDLE) begin
            tmo_n = '0;
            if (enable && rx_vld && rx_data == SYNC_BYTE) begin
                state_n = LD_A_HI;
                csum_n  = '0;
                code_n  = ERR_NONE;
            end
        end else if (!enable) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end else if (rx_ferr) begin
            abort      = 1'b1;
            abort_code = ERR_FRAME;
        end else if (rx_vld) begin
            tmo_n  = '0;
            csum_n = csum_add;
            case (state)
                LD_A_HI: begin
                    cur_addr_n[15:8] = rx_data;
                    state_n          = LD_A_LO;
                end
                LD_A_LO: begin
                    cur_addr_n[7:0] = rx_data;
                    state_n         = LD_L_HI;
                end
                LD_L_HI: begin
                    remain_n[15:8] = rx_data;
                    state_n        = LD_L_LO;
                end
                LD_L_LO: begin
                    remain_n[7:0] = rx_data;
                    state_n       = ({remain[15:8], rx_data} == 16'd0) ? LD_CHK : LD_DATA;
                end
                LD_DATA: begin
                    we_n       = 1'b1;
                    addr_n     = cur_addr;
                    data_n     = rx_data;
                    cur_addr_n = cur_addr + 16'd1;
                    remain_n   = remain - 16'd1;
                    if (remain == 16'd1) state_n = LD_CHK;
                end
                LD_CHK: begin
                    state_n = LD_IDLE;
                    if (csum_add == 8'd0) begin
                        done_n = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = ERR_CHK;
                    end
                end
                default: state_n = LD_IDLE;
            endcase
        end else if (tmo >= TW'(TIMEOUT_CYC - 1)) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end

        if (abort) begin
            state_n = LD_IDLE;
            err_n   = 1'b1;
            code_n  = abort_code;
        end
    end

    assign ld.mem_we   = we_q;
    assign ld.mem_addr = addr_q;
    assign ld.mem_data = data_q;
    assign ld.busy     = (state != LD_IDLE);
    assign ld.done     = done_q;
    assign ld.err      = err_q;
    assign ld.err_code = code_q;

endmodule

// File: tb/tb_altair_serial_loader.sv
// Self-checking bench for the serial loader: directed vectors, corner sequences, random frames.
// Latency: checks write order, pulse counts and codes after each frame settles.
// Backpressure: n/a.
module tb_altair_serial_loader;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int TMO    = 1000;

    logic clk, rst_n, enable, rx;
    altair_serial_loader_if bus();

    altair_serial_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .rx     (rx),
        .ld     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed activity, appended only by the monitor.
    logic [23:0] wr_q[$];
    int n_done = 0;
    int n_err  = 0;

    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_data});
        if (bus.done) n_done++;
        if (bus.err)  n_err++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (stop_ok ? 2 : 2 * BIT) @(negedge clk);
    endtask

    // Reference model: collects whole frames and derives writes/results from them.
    logic [23:0] exp_q[$];
    logic [7:0]  fr[$];
    bit          m_in = 0;
    int          m_done = 0;
    int          m_err = 0;
    logic [1:0]  m_code = 2'd0;

    task automatic model_byte(input logic [7:0] b);
        if (!m_in) begin
            if (b == 8'h55) begin
                m_in = 1;
                fr.delete();
            end
        end else begin
            fr.push_back(b);
            if (fr.size() >= 4) begin
                int len;
                len = fr[2] * 256 + fr[3];
                if (fr.size() == len + 5) begin
                    int s;
                    logic [15:0] a;
                    s = 0;
                    foreach (fr[i]) s += fr[i];
                    for (int i = 0; i < len; i++) begin
                        a = 16'((fr[0] * 256 + fr[1] + i) % 65536);
                        exp_q.push_back({a, fr[4 + i]});
                    end
                    if (s % 256 == 0) begin
                        m_done++;
                        m_code = 2'd0;
                    end else begin
                        m_err++;
                        m_code = 2'd1;
                    end
                    m_in = 0;
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0]  b[12];
        int          n;
        int          bad_idx;
        int          nw;
        logic [23:0] w[4];
        int          exp_done;
        int          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vt[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, bd, be, cyc;
        logic [7:0] q[$];

        // Directed frames; CHK bytes make the ADDR_HI..CHK sum wrap to zero unless marked bad.
        vt[0].b = '{8'h55,8'h00,8'h10,8'h00,8'h03,8'hAA,8'hBB,8'hCC,8'hBC,8'h00,8'h00,8'h00};
        vt[0].n = 9; vt[0].bad_idx = -1; vt[0].nw = 3;
        vt[0].w = '{24'h0010AA,24'h0011BB,24'h0012CC,24'h0};
        vt[0].exp_done = 1; vt[0].exp_err = 0; vt[0].exp_code = 2'd0;
        vt[1].b = '{8'h55,8'h00,8'h10,8'h00,8'h03,8'hAA,8'hBB,8'hCC,8'h00,8'h00,8'h00,8'h00};
        vt[1].n = 9; vt[1].bad_idx = -1; vt[1].nw = 3;
        vt[1].w = '{24'h0010AA,24'h0011BB,24'h0012CC,24'h0};
        vt[1].exp_done = 0; vt[1].exp_err = 1; vt[1].exp_code = 2'd1;
        vt[2].b = '{8'h55,8'hFF,8'hFF,8'h00,8'h02,8'h11,8'h22,8'hCD,8'h00,8'h00,8'h00,8'h00};
        vt[2].n = 8; vt[2].bad_idx = -1; vt[2].nw = 2;
        vt[2].w = '{24'hFFFF11,24'h000022,24'h0,24'h0};
        vt[2].exp_done = 1; vt[2].exp_err = 0; vt[2].exp_code = 2'd0;
        vt[3].b = '{8'h12,8'h34,8'h55,8'h01,8'h00,8'h00,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00};
        vt[3].n = 8; vt[3].bad_idx = -1; vt[3].nw = 0;
        vt[3].w = '{24'h0,24'h0,24'h0,24'h0};
        vt[3].exp_done = 1; vt[3].exp_err = 0; vt[3].exp_code = 2'd0;
        vt[4].b = '{8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        vt[4].n = 3; vt[4].bad_idx = 2; vt[4].nw = 0;
        vt[4].w = '{24'h0,24'h0,24'h0,24'h0};
        vt[4].exp_done = 0; vt[4].exp_err = 1; vt[4].exp_code = 2'd2;
        vt[5].b = '{8'h12,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        vt[5].n = 1; vt[5].bad_idx = 0; vt[5].nw = 0;
        vt[5].w = '{24'h0,24'h0,24'h0,24'h0};
        vt[5].exp_done = 0; vt[5].exp_err = 0; vt[5].exp_code = 2'd2;
        vt[6].b = '{8'h55,8'h00,8'h20,8'h00,8'h02,8'h55,8'h55,8'h34,8'h00,8'h00,8'h00,8'h00};
        vt[6].n = 8; vt[6].bad_idx = -1; vt[6].nw = 2;
        vt[6].w = '{24'h002055,24'h002155,24'h0,24'h0};
        vt[6].exp_done = 1; vt[6].exp_err = 0; vt[6].exp_code = 2'd0;

        rx = 1'b1; enable = 1'b1; rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_we",   bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err",  bus.err, 0);
        check("rst_code", bus.err_code, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            bw = wr_q.size(); bd = n_done; be = n_err;
            for (int j = 0; j < vt[k].n; j++) send_byte(vt[k].b[j], j != vt[k].bad_idx);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_nwr", k), wr_q.size() - bw, vt[k].nw);
            for (int j = 0; j < vt[k].nw && bw + j < wr_q.size(); j++)
                check($sformatf("v%0d_wr%0d", k, j), wr_q[bw + j], vt[k].w[j]);
            check($sformatf("v%0d_done", k), n_done - bd, vt[k].exp_done);
            check($sformatf("v%0d_err", k),  n_err - be,  vt[k].exp_err);
            check($sformatf("v%0d_code", k), bus.err_code, vt[k].exp_code);
            check($sformatf("v%0d_busy", k), bus.busy, 0);
        end

        // Host stalls mid-header: expect a timeout abort near TMO idle clocks.
        send_byte(8'h55, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        check("tmo_busy", bus.busy, 1);
        be = n_err; cyc = 0;
        while (n_err == be && cyc < 3 * TMO) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_seen", n_err - be, 1);
        check("tmo_window", (cyc >= TMO - 2 * BIT) && (cyc <= TMO + 2 * BIT), 1);
        @(negedge clk);
        check("tmo_code", bus.err_code, 3);
        check("tmo_busy_low", bus.busy, 0);
        bw = wr_q.size(); bd = n_done;
        q = '{8'h55, 8'h00, 8'h30, 8'h00, 8'h01, 8'h5A, 8'h75};
        foreach (q[i]) send_byte(q[i], 1);
        repeat (20) @(negedge clk);
        check("tmo_after_nwr", wr_q.size() - bw, 1);
        if (wr_q.size() > bw) check("tmo_after_wr", wr_q[bw], 24'h00305A);
        check("tmo_after_done", n_done - bd, 1);

        // Enable withdrawn mid-frame.
        be = n_err;
        send_byte(8'h55, 1); send_byte(8'h12, 1); send_byte(8'h34, 1);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("en_drop_err", n_err - be, 1);
        check("en_drop_code", bus.err_code, 3);
        check("en_drop_busy", bus.busy, 0);

        // Loader disarmed: a valid frame must be ignored entirely.
        bw = wr_q.size(); bd = n_done; be = n_err;
        for (int j = 0; j < vt[0].n; j++) send_byte(vt[0].b[j], 1);
        repeat (20) @(negedge clk);
        check("dis_nwr", wr_q.size() - bw, 0);
        check("dis_done", n_done - bd, 0);
        check("dis_busy", bus.busy, 0);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-DATA after one committed write.
        bw = wr_q.size();
        for (int j = 0; j < 6; j++) send_byte(vt[0].b[j], 1);
        repeat (5) @(negedge clk);
        check("mid_nwr", wr_q.size() - bw, 1);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",   bus.mem_we, 0);
        check("mid_rst_addr", bus.mem_addr, 0);
        check("mid_rst_data", bus.mem_data, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_err",  bus.err, 0);
        check("mid_rst_code", bus.err_code, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // Random frames with junk between them, checked against the frame model.
        bw = wr_q.size(); bd = n_done; be = n_err;
        for (int f = 0; f < 14; f++) begin
            logic [7:0] jb, chk;
            logic [15:0] a;
            int len, s;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'h55) jb = 8'h54;
                model_byte(jb);
                send_byte(jb, 1);
            end
            a = 16'($urandom);
            if (f % 4 == 0) a = 16'hFFFE;
            len = $urandom_range(0, 5);
            q = '{8'h55, a[15:8], a[7:0], 8'h00, 8'(len)};
            for (int j = 0; j < len; j++) q.push_back(8'($urandom_range(0, 255)));
            s = 0;
            for (int j = 1; j < q.size(); j++) s += q[j];
            chk = 8'((256 - (s % 256)) % 256);
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            q.push_back(chk);
            foreach (q[i]) begin
                model_byte(q[i]);
                send_byte(q[i], 1);
            end
        end
        repeat (20) @(negedge clk);
        check("rnd_nwr", wr_q.size() - bw, exp_q.size());
        for (int j = 0; j < exp_q.size() && bw + j < wr_q.size(); j++)
            check($sformatf("rnd_wr%0d", j), wr_q[bw + j], exp_q[j]);
        check("rnd_done", n_done - bd, m_done);
        check("rnd_err",  n_err - be,  m_err);
        check("rnd_code", bus.err_code, m_code);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
